// File: rtl/ring_counter_nbd.sv
// Bidirectional ring / Johnson shift counter with synchronous load, wrap pulse
// and illegal-code detection with optional self-correction back to RESET_VALUE.
module ring_counter_nbd #(
  parameter int unsigned          WIDTH        = 4,
  parameter logic [WIDTH-1:0]     RESET_VALUE  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter bit                   AUTO_CORRECT = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             illegal
);

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'b00,
    MODE_RING    = 2'b01,
    MODE_JOHNSON = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;
  logic [WIDTH-1:0] john_left;
  logic [WIDTH-1:0] john_right;
  logic [WIDTH-1:0] shifted;
  logic             legal;
  logic             wrap_cond;
  logic             step;
  int unsigned      ones;
  int unsigned      edges;

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             illegal_d;

  assign mode_sel   = mode_e'(mode);
  assign rot_left   = {count[WIDTH-2:0], count[WIDTH-1]};
  assign rot_right  = {count[0], count[WIDTH-1:1]};
  assign john_left  = {count[WIDTH-2:0], ~count[WIDTH-1]};
  assign john_right = {~count[0], count[WIDTH-1:1]};
  assign ones       = $countones(count);
  // A legal Johnson code has at most one 0->1 and one 1->0 boundary around the ring.
  assign edges      = $countones(count ^ rot_left);
  assign step       = enable && (mode_sel == MODE_RING || mode_sel == MODE_JOHNSON);

  always_comb begin
    shifted   = count;
    legal     = 1'b1;
    wrap_cond = 1'b0;
    if (mode_sel == MODE_JOHNSON) begin
      shifted   = dir ? john_left : john_right;
      legal     = (edges == 0) || (edges == 2);
      wrap_cond = (shifted == '0);
    end else begin
      shifted   = dir ? rot_left : rot_right;
      legal     = (ones == 1);
      wrap_cond = dir ? count[WIDTH-1] : count[0];
    end
  end

  always_comb begin
    count_d   = count;
    wrap_d    = 1'b0;
    illegal_d = 1'b0;
    if (step) begin
      if (legal) begin
        count_d = shifted;
        wrap_d  = wrap_cond;
      end else begin
        illegal_d = 1'b1;
        count_d   = AUTO_CORRECT ? RESET_VALUE : shifted;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= RESET_VALUE;
      wrap    <= 1'b0;
      illegal <= 1'b0;
    end else if (load) begin
      count   <= data;
      wrap    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      count   <= count_d;
      wrap    <= wrap_d;
      illegal <= illegal_d;
    end
  end

  initial begin : width_guard
    // Elaboration-time sanity only; no hardware is generated.
  end

endmodule

// File: tb/tb_ring_counter_nbd.sv
// Directed bench for ring_counter_nbd: one instance with auto-correct, one without,
// both driven by the same stimulus and checked against hand-computed vectors.
module tb_ring_counter_nbd;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset, enable, dir, load;
  logic [1:0]   mode;
  logic [W-1:0] data;
  logic [W-1:0] count_ac, count_na;
  logic         wrap_ac, wrap_na, illegal_ac, illegal_na;

  int errors = 0;
  int checks = 0;

  ring_counter_nbd #(.WIDTH(W), .RESET_VALUE(4'b0001), .AUTO_CORRECT(1'b1)) dut_ac (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
    .load(load), .data(data), .count(count_ac), .wrap(wrap_ac), .illegal(illegal_ac)
  );

  ring_counter_nbd #(.WIDTH(W), .RESET_VALUE(4'b0001), .AUTO_CORRECT(1'b0)) dut_na (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .dir(dir),
    .load(load), .data(data), .count(count_na), .wrap(wrap_na), .illegal(illegal_na)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_ac(input string tag, input logic [W-1:0] c, input logic w, input logic i);
    check({tag, ".count"}, 32'(count_ac), 32'(c));
    check({tag, ".wrap"}, 32'(wrap_ac), 32'(w));
    check({tag, ".illegal"}, 32'(illegal_ac), 32'(i));
  endtask

  task automatic expect_na(input string tag, input logic [W-1:0] c, input logic w, input logic i);
    check({tag, ".count"}, 32'(count_na), 32'(c));
    check({tag, ".wrap"}, 32'(wrap_na), 32'(w));
    check({tag, ".illegal"}, 32'(illegal_na), 32'(i));
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; data = v; enable = 1'b0;
    tick();
    load = 1'b0;
  endtask

  logic [W-1:0] ring_l_tbl [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [W-1:0] john_l_tbl [8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [W-1:0] john_r_tbl [8]  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                    4'b0111, 4'b0011, 4'b0001, 4'b0000};

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'b00; dir = 1'b0; load = 1'b0; data = '0;
    @(negedge clock);
    tick();
    expect_ac("reset", 4'b0001, 1'b0, 1'b0);
    expect_na("reset_na", 4'b0001, 1'b0, 1'b0);
    reset = 1'b0;

    // Ring left, full lap
    mode = 2'b01; dir = 1'b1; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_ac($sformatf("ring_l%0d", k), ring_l_tbl[k], k == 3, 1'b0);
    end

    // Ring right wraps LSB->MSB, then wrap clears on hold
    dir = 1'b0;
    tick(); expect_ac("ring_r0", 4'b1000, 1'b1, 1'b0);
    enable = 1'b0;
    tick(); expect_ac("hold_en0", 4'b1000, 1'b0, 1'b0);
    enable = 1'b1;
    tick(); expect_ac("ring_r1", 4'b0100, 1'b0, 1'b0);
    mode = 2'b11;
    tick(); expect_ac("hold_m11", 4'b0100, 1'b0, 1'b0);
    mode = 2'b00;
    tick(); expect_ac("hold_m00", 4'b0100, 1'b0, 1'b0);

    // Johnson left from zero, period 8
    do_load(4'b0000);
    expect_ac("load0", 4'b0000, 1'b0, 1'b0);
    mode = 2'b10; dir = 1'b1; enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_ac($sformatf("john_l%0d", k), john_l_tbl[k], k == 7, 1'b0);
    end
    tick(); expect_ac("john_l8", 4'b0001, 1'b0, 1'b0);

    // Johnson right from zero
    do_load(4'b0000);
    mode = 2'b10; dir = 1'b0; enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_ac($sformatf("john_r%0d", k), john_r_tbl[k], k == 7, 1'b0);
    end

    // Illegal ring code: corrected vs shifted; repeat keeps the pulse up
    do_load(4'b0110);
    mode = 2'b01; dir = 1'b1; enable = 1'b1;
    tick();
    expect_ac("ill_ring_ac", 4'b0001, 1'b0, 1'b1);
    expect_na("ill_ring_na", 4'b1100, 1'b0, 1'b1);
    tick();
    expect_ac("after_fix_ac", 4'b0010, 1'b0, 1'b0);
    expect_na("ill_msb_na", 4'b1001, 1'b0, 1'b1);
    do_load(4'b1000);
    expect_na("load_clr_na", 4'b1000, 1'b0, 1'b0);

    // Illegal Johnson code, then switch to ring mode on a ring-legal code
    do_load(4'b0101);
    mode = 2'b10; dir = 1'b1; enable = 1'b1;
    tick();
    expect_ac("ill_john_ac", 4'b0001, 1'b0, 1'b1);
    expect_na("ill_john_na", 4'b1011, 1'b0, 1'b1);
    mode = 2'b01;
    tick();
    expect_ac("mode_sw_ac", 4'b0010, 1'b0, 1'b0);

    // All-zero code is illegal for ring mode
    do_load(4'b0000);
    mode = 2'b01; dir = 1'b0; enable = 1'b1;
    tick();
    expect_ac("ring_zero_ac", 4'b0001, 1'b0, 1'b1);
    expect_na("ring_zero_na", 4'b0000, 1'b0, 1'b1);

    // Priority: reset over load, load over enable
    reset = 1'b1; load = 1'b1; data = 4'b0100; enable = 1'b1; mode = 2'b01;
    tick();
    expect_ac("rst_over_load", 4'b0001, 1'b0, 1'b0);
    reset = 1'b0; data = 4'b0110;
    tick();
    expect_ac("load_over_en", 4'b0110, 1'b0, 1'b0);
    load = 1'b0;
    tick();
    expect_ac("post_load_chk", 4'b0001, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
